// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and the pattern-to-BCD mapping.
// Also used by the decoder-side bench.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h72;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_HOLD
  } cap_state_t;

  function automatic logic [3:0] seg7_code(
    input logic [6:0] seg
  );
    logic [3:0] c;
    case (seg)
      SEG_0:     c = 4'd0;
      SEG_1:     c = 4'd1;
      SEG_2:     c = 4'd2;
      SEG_3:     c = 4'd3;
      SEG_4:     c = 4'd4;
      SEG_5:     c = 4'd5;
      SEG_6:     c = 4'd6;
      SEG_7:     c = 4'd7;
      SEG_8:     c = 4'd8;
      SEG_9:     c = 4'd9;
      SEG_BLANK: c = CODE_BLANK;
      default:   c = CODE_ERR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational 7-segment pattern to BCD encoder.
// Unknown patterns map to CODE_ERR and raise o_err.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_code,
  output logic       o_err
);

  assign o_code = seg7_code(i_seg);
  assign o_err  = (o_code == CODE_ERR);

endmodule

// File: rtl/seg7_scan_capture.sv
// Sniffs a multiplexed 7-segment bus and rebuilds
// complete BCD frames behind a valid/ready handshake.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] frame_data,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    seg_err,
  output logic                    overrun,
  input  logic                    clr_sticky
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [6:0]              r_seg;
  logic [6:0]              r_seg_p;
  logic [NUM_DIGITS-1:0]   r_dig;
  logic [NUM_DIGITS-1:0]   r_dig_p;
  logic [NUM_DIGITS-1:0]   r_mask;
  logic [NUM_DIGITS-1:0]   w_mask_set;
  cap_state_t              r_state;
  cap_state_t              w_state_nxt;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           w_cnt_nxt;
  logic [4*NUM_DIGITS-1:0] r_slot;
  logic [4*NUM_DIGITS-1:0] w_slot_nxt;
  logic [4*NUM_DIGITS-1:0] r_frame;
  logic                    r_valid;
  logic                    r_err;
  logic                    r_ovr;
  logic                    w_onehot;
  logic                    w_same;
  logic                    w_cap;
  logic                    w_full;
  logic                    w_load;
  logic                    w_err;
  logic [3:0]              w_code;

  seg7_encode u_enc (
    .i_seg  (r_seg),
    .o_code (w_code),
    .o_err  (w_err)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_seg   <= '0;
      r_dig   <= '0;
      r_seg_p <= '0;
      r_dig_p <= '0;
    end else begin
      r_seg   <= seg_in;
      r_dig   <= dig_sel;
      r_seg_p <= r_seg;
      r_dig_p <= r_dig;
    end
  end

  assign w_onehot = $onehot(r_dig);
  assign w_same   = (r_seg == r_seg_p)
                 && (r_dig == r_dig_p);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cap       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_onehot) begin
          w_state_nxt = ST_TRACK;
          w_cnt_nxt   = CW'(1);
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      ST_TRACK, ST_HOLD: begin
        if (w_same) begin
          if (r_state == ST_TRACK && r_cnt != CNT_MAX)
            w_cnt_nxt = r_cnt + CW'(1);
        end else if (w_onehot) begin
          w_state_nxt = ST_TRACK;
          w_cnt_nxt   = CW'(1);
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    // A restart can also satisfy the threshold when it is 1.
    if (w_state_nxt == ST_TRACK && w_cnt_nxt >= CNT_MAX) begin
      w_cap       = 1'b1;
      w_state_nxt = ST_HOLD;
    end
  end

  always_comb begin
    w_slot_nxt = r_slot;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_cap && r_dig[i])
        w_slot_nxt[4*i +: 4] = w_code;
    end
  end

  assign w_mask_set = w_cap ? r_dig : '0;
  assign w_full     = &r_mask;
  assign w_load     = w_full
                   && (!r_valid || frame_ready);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_mask  <= '0;
      r_slot  <= '0;
      r_frame <= '0;
      r_valid <= 1'b0;
    end else begin
      r_mask <= w_full ? w_mask_set
                       : (r_mask | w_mask_set);
      r_slot <= w_slot_nxt;
      if (w_load) begin
        r_frame <= r_slot;
        r_valid <= 1'b1;
      end else if (r_valid && frame_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_err <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      if (w_cap && w_err)
        r_err <= 1'b1;
      else if (clr_sticky)
        r_err <= 1'b0;
      if (w_full && !w_load)
        r_ovr <= 1'b1;
      else if (clr_sticky)
        r_ovr <= 1'b0;
    end
  end

  assign frame_data  = r_frame;
  assign frame_valid = r_valid;
  assign seg_err     = r_err;
  assign overrun     = r_ovr;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: table frames, corner
// sequences and random scanning against a run-length model.
module tb_seg7_scan_capture;

  localparam int ND = 4;
  localparam int SC = 8;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [6:0]    seg_in;
  logic [ND-1:0] dig_sel;
  logic [15:0]   frame_data;
  logic          frame_valid;
  logic          frame_ready;
  logic          seg_err;
  logic          overrun;
  logic          clr_sticky;

  always #5 aclk = ~aclk;

  seg7_scan_capture #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .seg_err     (seg_err),
    .overrun     (overrun),
    .clr_sticky  (clr_sticky)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_vpulse;

  logic [6:0] pats [10] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
    7'h5B, 7'h5F, 7'h72, 7'h7F, 7'h7B
  };

  // model: run length of identical input cycles
  logic [6:0]  p_seg;
  logic [3:0]  p_dig;
  int          run_len;
  bit          cap_prev;
  logic [6:0]  cap_seg;
  logic [3:0]  cap_dig;
  logic [15:0] m_slot;
  logic [15:0] m_data;
  logic [3:0]  m_mask;
  bit          m_valid;
  bit          m_err;
  bit          m_ovr;

  function automatic logic [3:0] ref_code(
    input logic [6:0] s
  );
    if (s == 7'h00) return 4'hF;
    for (int i = 0; i < 10; i++)
      if (pats[i] == s) return 4'(i);
    return 4'hE;
  endfunction

  function automatic int idx_of(input logic [3:0] d);
    for (int i = 0; i < ND; i++)
      if (d[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    p_seg    = '0;
    p_dig    = '0;
    run_len  = 0;
    cap_prev = 0;
    cap_seg  = '0;
    cap_dig  = '0;
    m_slot   = '0;
    m_data   = '0;
    m_mask   = '0;
    m_valid  = 0;
    m_err    = 0;
    m_ovr    = 0;
  endtask

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic cyc(
    input logic [6:0] s,
    input logic [3:0] d,
    input bit         rdy,
    input bit         clr
  );
    bit          cap_now;
    bit          err_set;
    bit          ovr_set;
    logic [15:0] old;
    int          k;
    seg_in      = s;
    dig_sel     = d;
    frame_ready = rdy;
    clr_sticky  = clr;
    if (s == p_seg && d == p_dig) run_len++;
    else run_len = 1;
    cap_now = ($countones(d) == 1) && (run_len == SC);
    p_seg = s;
    p_dig = d;
    @(posedge aclk);
    #1;
    old     = m_slot;
    err_set = 0;
    ovr_set = 0;
    if (m_mask == 4'hF) begin
      m_mask = '0;
      if (!m_valid || rdy) begin
        m_data  = old;
        m_valid = 1;
      end else begin
        ovr_set = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (cap_prev) begin
      k = idx_of(cap_dig);
      m_slot[4*k +: 4] = ref_code(cap_seg);
      m_mask = m_mask | cap_dig;
      err_set = (ref_code(cap_seg) == 4'hE);
    end
    if (err_set) m_err = 1;
    else if (clr) m_err = 0;
    if (ovr_set) m_ovr = 1;
    else if (clr) m_ovr = 0;
    cap_prev = cap_now;
    cap_seg  = s;
    cap_dig  = d;
    check("cycle_outputs",
          {13'd0, frame_data, frame_valid, seg_err, overrun},
          {13'd0, m_data, m_valid, m_err, m_ovr});
    if (frame_valid) n_vpulse++;
  endtask

  task automatic dwell(
    input logic [6:0] s,
    input logic [3:0] d,
    input int         n,
    input bit         rdy
  );
    for (int i = 0; i < n; i++) cyc(s, d, rdy, 1'b0);
  endtask

  task automatic scan(
    input logic [3:0][6:0] segs,
    input int              dw,
    input bit              rdy
  );
    for (int i = 0; i < ND; i++)
      dwell(segs[i], 4'(1 << i), dw, rdy);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    dig_sel = '0;
    seg_in  = '0;
    #1;
    check("reset_outputs",
          {13'd0, frame_data, frame_valid, seg_err, overrun},
          32'd0);
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  typedef struct {
    logic [3:0][6:0] segs;
    int              dw;
    logic [15:0]     exp_data;
    bit              exp_err;
  } vec_t;

  vec_t tbl [4];

  initial begin
    logic [3:0][6:0] sq;
    tbl[0] = '{'{7'h33, 7'h79, 7'h6D, 7'h30},  8, 16'h4321, 0};
    tbl[1] = '{'{7'h7B, 7'h72, 7'h5F, 7'h7E}, 10, 16'h9760, 0};
    tbl[2] = '{'{7'h01, 7'h00, 7'h5B, 7'h7F},  8, 16'hEF58, 1};
    tbl[3] = '{'{7'h7E, 7'h6D, 7'h30, 7'h79},  9, 16'h0213, 1};

    frame_ready = 1'b0;
    clr_sticky  = 1'b0;
    n_vpulse    = 0;
    @(posedge aclk);
    #1;
    do_reset();

    for (int i = 0; i < 4; i++) begin
      n_vpulse = 0;
      scan(tbl[i].segs, tbl[i].dw, 1'b1);
      dwell(7'h00, 4'h0, 3, 1'b1);
      check("tbl_data", frame_data, tbl[i].exp_data);
      check("tbl_pulse", n_vpulse, 1);
      check("tbl_err", seg_err, tbl[i].exp_err);
    end
    cyc(7'h00, 4'h0, 1'b1, 1'b1);
    check("err_cleared", seg_err, 0);

    // 7-cycle dwell must not capture, 8 must
    n_vpulse = 0;
    dwell(7'h30, 4'b0001, SC - 1, 1'b1);
    dwell(7'h6D, 4'b0010, SC, 1'b1);
    dwell(7'h79, 4'b0100, SC, 1'b1);
    dwell(7'h33, 4'b1000, SC, 1'b1);
    dwell(7'h00, 4'h0, 3, 1'b1);
    check("short_dwell_pulse", n_vpulse, 0);
    dwell(7'h7E, 4'b0001, SC, 1'b1);
    dwell(7'h00, 4'h0, 3, 1'b1);
    check("full_dwell_pulse", n_vpulse, 1);
    check("full_dwell_data", frame_data, 16'h4320);

    // held frame, second frame dropped
    sq = {7'h33, 7'h79, 7'h6D, 7'h30};
    scan(sq, SC, 1'b0);
    dwell(7'h00, 4'h0, 3, 1'b0);
    check("hold_valid", frame_valid, 1);
    sq = {7'h7E, 7'h7E, 7'h7E, 7'h7E};
    scan(sq, SC, 1'b0);
    dwell(7'h00, 4'h0, 3, 1'b0);
    check("overrun_set", overrun, 1);
    check("overrun_data", frame_data, 16'h4321);
    cyc(7'h00, 4'h0, 1'b1, 1'b0);
    check("consume_valid", frame_valid, 0);
    check("consume_data", frame_data, 16'h4321);
    cyc(7'h00, 4'h0, 1'b1, 1'b1);
    check("overrun_cleared", overrun, 0);

    // non-one-hot selects never fill the missing slot
    n_vpulse = 0;
    dwell(7'h5B, 4'b0010, SC, 1'b1);
    dwell(7'h5B, 4'b0100, SC, 1'b1);
    dwell(7'h5B, 4'b1000, SC, 1'b1);
    dwell(7'h30, 4'b0011, 20, 1'b1);
    dwell(7'h30, 4'b0000, 20, 1'b1);
    check("nonhot_pulse", n_vpulse, 0);
    dwell(7'h5B, 4'b0001, SC, 1'b1);
    dwell(7'h00, 4'h0, 3, 1'b1);
    check("nonhot_then_frame", frame_data, 16'h5555);

    // reset mid-dwell discards partial mask
    dwell(7'h30, 4'b0001, SC, 1'b1);
    dwell(7'h30, 4'b0010, SC, 1'b1);
    dwell(7'h30, 4'b0100, 4, 1'b1);
    do_reset();
    n_vpulse = 0;
    dwell(7'h7F, 4'b0100, SC, 1'b1);
    dwell(7'h7F, 4'b1000, SC, 1'b1);
    dwell(7'h00, 4'h0, 3, 1'b1);
    check("reset_partial_pulse", n_vpulse, 0);
    dwell(7'h72, 4'b0001, SC, 1'b1);
    dwell(7'h72, 4'b0010, SC, 1'b1);
    dwell(7'h00, 4'h0, 3, 1'b1);
    check("reset_new_frame", frame_data, 16'h8877);

    // random scanning
    for (int n = 0; n < 300; n++) begin
      logic [6:0] s;
      logic [3:0] d;
      int         len;
      int         r;
      r = int'($urandom_range(0, 9));
      if (r < 7) s = pats[$urandom_range(0, 9)];
      else if (r == 7) s = 7'h00;
      else s = 7'($urandom);
      if ($urandom_range(0, 5) == 0) d = 4'($urandom);
      else d = 4'(1 << $urandom_range(0, 3));
      len = int'($urandom_range(1, 12));
      for (int j = 0; j < len; j++)
        cyc(s, d, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
